// File: rtl/axi4_pkg.sv
// Shared types for the AXI4 burst slave.
//   resp_t      : AXI response codes, numerically ordered so a larger value is a worse response
//   burst_t     : AXI burst types (encoding 3 is reserved)
//   wr_state_t  : write channel FSM states
//   rd_state_t  : read channel FSM states
//   resp_max()  : returns the worse of two responses, used to accumulate a burst's BRESP
package axi4_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic resp_t resp_max(input resp_t a, input resp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_slv_ram.sv
// Word-addressed RAM backing the AXI4 burst slave.
//   clock : rising-edge clock
//   we    : write enable; bytes selected by wstrb are written at waddr
//   waddr / wdata / wstrb : write port
//   re    : read enable; rdata loads mem[raddr] on the clock edge and holds otherwise
//   raddr / rdata : registered read port (read-before-write on a same-word collision)
// The array itself is never reset so its contents survive a reset pulse.
module axi4_slv_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024
) (
  input  logic                         clock,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         re,
  input  logic [$clog2(MEM_WORDS)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]        rdata
);

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/axi4_burst_slave.sv
// AXI4 memory responder: accepts AW/W/B and AR/R bursts against an internal RAM.
// Write and read channels are fully independent.
//
// Handshake rule on every channel: a transfer happens on the rising clock edge where
// VALID and READY are both high; the sender keeps VALID and payload stable until then,
// and READY never depends combinationally on VALID here.
//
// Ports
//   clock, reset (async, active-low)
//   AW*  : write address (AWID echoed on BID), AWREADY out
//   W*   : write data with byte strobes and WLAST, WREADY out
//   B*   : write response BID/BRESP, BVALID out, BREADY in
//   AR*  : read address (ARID echoed on RID), ARREADY out
//   R*   : read data RID/RDATA/RRESP/RLAST, RVALID out, RREADY in
//   wr_state_dbg / rd_state_dbg : current FSM states for observation
//
// Optional build macro AXI4_SLV_DECERR_EN: beats outside the decoded window answer DECERR
// (write dropped, RDATA=0). Without it every address aliases into the RAM modulo its size.
module axi4_burst_slave
  import axi4_pkg::*;
#(
  parameter int                    ID_WIDTH   = 1,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     AWID,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [2:0]              AWSIZE,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [ID_WIDTH-1:0]     BID,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ID_WIDTH-1:0]     ARID,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [2:0]              ARSIZE,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [ID_WIDTH-1:0]     RID,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY,
  output wr_state_t               wr_state_dbg,
  output rd_state_t               rd_state_dbg
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int IDX_W    = $clog2(MEM_WORDS);

  // RAM word for a byte address; the subtraction wraps, so addresses below BASE_ADDR alias too.
  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> ADDR_LSB);
  endfunction

`ifdef AXI4_SLV_DECERR_EN
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(MEM_WORDS * BYTES);

  function automatic logic in_window(input logic [ADDR_WIDTH-1:0] a);
    return (a >= BASE_ADDR) && ((a - BASE_ADDR) < SPAN);
  endfunction
`endif

  // READY outputs stay low until the first clock after reset is released.
  logic ready_en_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ready_en_q <= 1'b0;
    else        ready_en_q <= 1'b1;
  end

  // ---------------------------------------------------------------- write channel
  wr_state_t             wr_state, wr_next;
  logic [ID_WIDTH-1:0]   wr_id_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_step_q;
  logic [7:0]            wr_len_q, wr_cnt_q;
  logic                  wr_drop_q;
  resp_t                 wr_resp_q, wr_beat_resp;
  logic                  aw_hs, w_hs, wr_last, wr_oob, aw_unsup;

  assign aw_hs   = AWVALID & AWREADY;
  assign w_hs    = WVALID & WREADY;
  assign wr_last = (wr_cnt_q == wr_len_q);
  // WRAP and the reserved encoding are not supported; oversize beats cannot be honoured either.
  assign aw_unsup = (AWBURST == WRAP) || (AWBURST == 2'd3) || (AWSIZE > 3'(ADDR_LSB));

`ifdef AXI4_SLV_DECERR_EN
  assign wr_oob = !in_window(wr_addr_q);
`else
  assign wr_oob = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) wr_state <= W_IDLE;
    else        wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (wr_state)
      W_IDLE: begin
        AWREADY = ready_en_q;
        if (AWVALID && ready_en_q) wr_next = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        // The beat count, not WLAST, ends the data phase.
        if (WVALID && wr_last) wr_next = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    wr_beat_resp = wr_resp_q;
    if (WLAST != wr_last)      wr_beat_resp = resp_max(wr_beat_resp, SLVERR);
    if (wr_oob && !wr_drop_q)  wr_beat_resp = resp_max(wr_beat_resp, DECERR);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_id_q   <= '0;
      wr_addr_q <= '0;
      wr_step_q <= '0;
      wr_len_q  <= '0;
      wr_cnt_q  <= '0;
      wr_drop_q <= 1'b0;
      wr_resp_q <= OKAY;
    end else if (aw_hs) begin
      wr_id_q   <= AWID;
      wr_addr_q <= AWADDR;
      wr_step_q <= (AWBURST == FIXED) ? '0 : (ADDR_WIDTH'(1) << AWSIZE);
      wr_len_q  <= AWLEN;
      wr_cnt_q  <= '0;
      wr_drop_q <= aw_unsup;
      wr_resp_q <= aw_unsup ? SLVERR : OKAY;
    end else if (w_hs) begin
      if (!wr_last) wr_cnt_q <= wr_cnt_q + 8'd1;
      wr_addr_q <= wr_addr_q + wr_step_q;
      wr_resp_q <= wr_beat_resp;
    end
  end

  assign BID   = wr_id_q;
  assign BRESP = wr_resp_q;

  // ---------------------------------------------------------------- read channel
  rd_state_t             rd_state, rd_next;
  logic [ID_WIDTH-1:0]   rd_id_q;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_step_q, rd_addr_nxt;
  logic [7:0]            rd_len_q, rd_cnt_q;
  resp_t                 rd_resp_q;
  logic                  rd_zero_q;
  logic                  ar_hs, r_hs, rd_last, rd_oob, ram_re;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign ar_hs   = ARVALID & ARREADY;
  assign r_hs    = RVALID & RREADY;
  assign rd_last = (rd_cnt_q == rd_len_q);
  // Address of the beat that will be presented next: the RAM is read one cycle ahead so a
  // beat is ready the cycle after its predecessor is accepted.
  assign rd_addr_nxt = ar_hs ? ARADDR : (rd_addr_q + rd_step_q);
  assign ram_re      = ar_hs | (r_hs & !rd_last);

`ifdef AXI4_SLV_DECERR_EN
  assign rd_oob = !in_window(rd_addr_nxt);
`else
  assign rd_oob = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_state <= R_IDLE;
    else        rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    case (rd_state)
      R_IDLE: begin
        ARREADY = ready_en_q;
        if (ARVALID && ready_en_q) rd_next = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY && rd_last) rd_next = R_IDLE;
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_id_q   <= '0;
      rd_addr_q <= '0;
      rd_step_q <= '0;
      rd_len_q  <= '0;
      rd_cnt_q  <= '0;
      rd_resp_q <= OKAY;
      rd_zero_q <= 1'b1;
    end else if (ar_hs) begin
      rd_id_q   <= ARID;
      rd_addr_q <= ARADDR;
      // Reads treat every non-FIXED burst as incrementing.
      rd_step_q <= (ARBURST == FIXED) ? '0 : (ADDR_WIDTH'(1) << ARSIZE);
      rd_len_q  <= ARLEN;
      rd_cnt_q  <= '0;
      rd_resp_q <= rd_oob ? DECERR : OKAY;
      rd_zero_q <= rd_oob;
    end else if (r_hs && !rd_last) begin
      rd_cnt_q  <= rd_cnt_q + 8'd1;
      rd_addr_q <= rd_addr_nxt;
      rd_resp_q <= rd_oob ? DECERR : OKAY;
      rd_zero_q <= rd_oob;
    end
  end

  assign RID   = rd_id_q;
  assign RRESP = rd_resp_q;
  assign RLAST = (rd_state == R_DATA) && rd_last;
  // rd_zero_q also forces RDATA to 0 while in reset without resetting the RAM output.
  assign RDATA = rd_zero_q ? '0 : ram_rdata;

  assign wr_state_dbg = wr_state;
  assign rd_state_dbg = rd_state;

  axi4_slv_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_WORDS  (MEM_WORDS)
  ) u_ram (
    .clock (clock),
    .we    (w_hs & !wr_drop_q & !wr_oob),
    .waddr (word_idx(wr_addr_q)),
    .wdata (WDATA),
    .wstrb (WSTRB),
    .re    (ram_re),
    .raddr (word_idx(rd_addr_nxt)),
    .rdata (ram_rdata)
  );

endmodule
